// File: rtl/mult_sweep_pkg.sv
// rtl/mult_sweep_pkg.sv - shared types and constants for the multiplier sweep scorer
package mult_sweep_pkg;

    localparam int DEF_W     = 4;
    localparam int DEF_ACC_W = 16;
    localparam int PAIRS     = 2 ** (2 * DEF_W);
    localparam int PROD_W    = 2 * DEF_W;
    localparam int DIFF_W    = PROD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mult_sweep_scorer_if.sv
// rtl/mult_sweep_scorer_if.sv - scorer control/MUT/metric bundle; err_bias present with MULT_SWEEP_BIAS_EN
interface mult_sweep_scorer_if #(
    parameter int W     = 4,
    parameter int ACC_W = 16
);
    logic                 start;
    logic [W-1:0]         op_a;
    logic [W-1:0]         op_b;
    logic [2*W-1:0]       prod_in;
    logic                 busy;
    logic                 done;
    logic [2*W:0]         err_count;
    logic [ACC_W-1:0]     err_sum;
    logic [2*W-1:0]       err_max;
`ifdef MULT_SWEEP_BIAS_EN
    logic signed [ACC_W:0] err_bias;

    modport master (
        output start, prod_in,
        input  op_a, op_b, busy, done, err_count, err_sum, err_max, err_bias
    );
    modport slave (
        input  start, prod_in,
        output op_a, op_b, busy, done, err_count, err_sum, err_max, err_bias
    );
`else
    modport master (
        output start, prod_in,
        input  op_a, op_b, busy, done, err_count, err_sum, err_max
    );
    modport slave (
        input  start, prod_in,
        output op_a, op_b, busy, done, err_count, err_sum, err_max
    );
`endif
endinterface

// File: rtl/mult_err_accum.sv
// rtl/mult_err_accum.sv - compare stage and saturating error metrics; err_bias with MULT_SWEEP_BIAS_EN
module mult_err_accum #(
    parameter int W     = 4,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [2*W-1:0]       exact,
    input  logic [2*W-1:0]       actual,
    output logic [2*W:0]         err_count,
    output logic [ACC_W-1:0]     err_sum,
    output logic [2*W-1:0]       err_max
`ifdef MULT_SWEEP_BIAS_EN
    ,
    output logic signed [ACC_W:0] err_bias
`endif
);
    localparam int PW = 2 * W;
    localparam int EW = PW + 1;
    localparam int SW = ACC_W + 1;
    localparam int BW = ACC_W + 2;

    logic [PW-1:0]    exact_q, exact_d, actual_q, actual_d;
    logic             valid_q, valid_d;
    logic [PW:0]      count_q, count_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [PW-1:0]    max_q, max_d;
    logic [ACC_W:0]   bias_q, bias_d;

    logic [EW-1:0]    diff;
    logic [PW-1:0]    mag;
    logic [SW-1:0]    sum_ext;
    logic [BW-1:0]    bias_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exact_q  <= '0;
            actual_q <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            sum_q    <= '0;
            max_q    <= '0;
            bias_q   <= '0;
        end else begin
            exact_q  <= exact_d;
            actual_q <= actual_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            max_q    <= max_d;
            bias_q   <= bias_d;
        end
    end

    always_comb begin
        exact_d  = exact;
        actual_d = actual;
        valid_d  = valid & ~clear;
        count_d  = count_q;
        sum_d    = sum_q;
        max_d    = max_q;
        bias_d   = bias_q;

        diff     = {1'b0, actual_q} - {1'b0, exact_q};
        mag      = diff[EW-1] ? (exact_q - actual_q) : (actual_q - exact_q);
        sum_ext  = {1'b0, sum_q} + SW'(mag);
        // Signed sum is widened by one bit so overflow shows as a sign-bit disagreement.
        bias_ext = {bias_q[ACC_W], bias_q} + {{(BW-EW){diff[EW-1]}}, diff};

        if (clear) begin
            count_d = '0;
            sum_d   = '0;
            max_d   = '0;
            bias_d  = '0;
        end else if (valid_q) begin
            if (mag != '0)
                count_d = count_q + 1'b1;
            sum_d = sum_ext[SW-1] ? '1 : sum_ext[ACC_W-1:0];
            if (mag > max_q)
                max_d = mag;
            if (bias_ext[BW-1] != bias_ext[BW-2])
                bias_d = bias_ext[BW-1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
            else
                bias_d = bias_ext[ACC_W:0];
        end
    end

    assign err_count = count_q;
    assign err_sum   = sum_q;
    assign err_max   = max_q;
`ifdef MULT_SWEEP_BIAS_EN
    assign err_bias  = $signed(bias_q);
`endif

endmodule

// File: rtl/mult_sweep_scorer.sv
// rtl/mult_sweep_scorer.sv - sweeps all operand pairs through a MUT and scores it; optional MULT_SWEEP_BIAS_EN
module mult_sweep_scorer
    import mult_sweep_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_sweep_scorer_if.slave bus
);
    localparam int PW = 2 * W;

    state_e        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          clear;
    logic          cap_valid;
    logic [PW-1:0] exact;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        clear     = 1'b0;
        cap_valid = (state_q == ST_SWEEP);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    clear   = 1'b1;
                end
            end
            ST_SWEEP: begin
                // Counter parks on the last pair so operands hold all-ones afterwards.
                if (cnt_q == '1)
                    state_d = ST_DRAIN;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.op_a = cnt_q[W-1:0];
    assign bus.op_b = cnt_q[PW-1:W];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign exact    = PW'(bus.op_a) * PW'(bus.op_b);

    mult_err_accum #(.W(W), .ACC_W(ACC_W)) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .valid     (cap_valid),
        .exact     (exact),
        .actual    (bus.prod_in),
        .err_count (bus.err_count),
        .err_sum   (bus.err_sum),
        .err_max   (bus.err_max)
`ifdef MULT_SWEEP_BIAS_EN
        ,
        .err_bias  (bus.err_bias)
`endif
    );

endmodule

// File: tb/tb_mult_sweep_scorer.sv
// tb/tb_mult_sweep_scorer.sv - self-checking bench for mult_sweep_scorer (MULT_SWEEP_BIAS_EN aware)
module tb_mult_sweep_scorer;
    localparam int W     = 4;
    localparam int ACC_W = 16;
    localparam longint SUM_MAX  = (64'd1 << ACC_W) - 1;
    localparam longint BIAS_MAX = (64'd1 << ACC_W) - 1;
    localparam longint BIAS_MIN = -(64'd1 << ACC_W);

    logic clk = 1'b0;
    logic rst_n;
    int   mode;
    int   m_k;
    int   m_mode;
    bit   chk_en;
    int   n_chk;
    int   n_fail;

    always #5 clk = ~clk;

    mult_sweep_scorer_if #(.W(W), .ACC_W(ACC_W)) bus ();

    mult_sweep_scorer #(.W(W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // MUT models: 0 exact, 1 stuck at zero, 2 off by one, 3 xor-corrupted
    function automatic int prod_of(int m, int a, int b);
        case (m)
            0:       return a * b;
            1:       return 0;
            2:       return (a * b + 1) % 256;
            default: return ((a * b) ^ (b << 2)) & 255;
        endcase
    endfunction

    always_comb bus.prod_in = 8'(prod_of(mode, int'(bus.op_a), int'(bus.op_b)));

    // Metrics expected after the first n pairs of the sweep order (op_a fastest).
    task automatic metrics_after(input int m, input int n,
                                 output longint c, output longint s,
                                 output longint mx, output longint bi);
        c = 0; s = 0; mx = 0; bi = 0;
        for (int j = 0; j < n; j++) begin
            longint d;
            longint ad;
            d  = prod_of(m, j % 16, j / 16) - (j % 16) * (j / 16);
            ad = (d < 0) ? -d : d;
            if (d != 0) c++;
            s = (s + ad > SUM_MAX) ? SUM_MAX : s + ad;
            if (ad > mx) mx = ad;
            bi = bi + d;
            if (bi > BIAS_MAX) bi = BIAS_MAX;
            if (bi < BIAS_MIN) bi = BIAS_MIN;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // m_k counts clock edges since the accepted start, inclusive; -1 means no sweep since reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_k <= -1;
        end else if (bus.start && !(m_k >= 1 && m_k <= 257)) begin
            m_k    <= 1;
            m_mode <= mode;
        end else if (m_k >= 1 && m_k < 400) begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            longint c, s, mx, bi;
            int n, pair;
            n    = (m_k < 3) ? 0 : ((m_k - 2 > 256) ? 256 : m_k - 2);
            pair = (m_k < 1) ? 0 : ((m_k - 1 > 255) ? 255 : m_k - 1);
            metrics_after(m_mode, n, c, s, mx, bi);
            chk("busy",      bus.busy, (m_k >= 1 && m_k <= 257) ? 1 : 0);
            chk("done",      bus.done, (m_k >= 258) ? 1 : 0);
            chk("op_a",      bus.op_a, pair % 16);
            chk("op_b",      bus.op_b, pair / 16);
            chk("err_count", bus.err_count, c);
            chk("err_sum",   bus.err_sum, s);
            chk("err_max",   bus.err_max, mx);
`ifdef MULT_SWEEP_BIAS_EN
            chk("err_bias",  longint'(bus.err_bias), bi);
`endif
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits for done; cycles counts edges from the one that samples start.
    task automatic wait_done(input int already, output int cycles);
        cycles = already;
        while (!bus.done && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        chk("done_latency", cycles, 258);
    endtask

    task automatic full_sweep(input int m, output int cycles);
        mode = m;
        pulse_start();
        wait_done(1, cycles);
    endtask

    task automatic chk_final(input string tag, input longint c, input longint s,
                             input longint mx, input longint bi);
        chk({tag, "_count"}, bus.err_count, c);
        chk({tag, "_sum"},   bus.err_sum, s);
        chk({tag, "_max"},   bus.err_max, mx);
`ifdef MULT_SWEEP_BIAS_EN
        chk({tag, "_bias"},  longint'(bus.err_bias), bi);
`else
        if (bi != 0 && bi == 0) chk({tag, "_bias"}, 0, 1);
`endif
    endtask

    initial begin
        int cyc;
        longint c, s, mx, bi;
        n_chk = 0; n_fail = 0; chk_en = 0;
        m_k = -1; m_mode = 0; mode = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1;

        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk_final("rst", 0, 0, 0, 0);

        full_sweep(0, cyc);
        chk_final("exact", 0, 0, 0, 0);

        full_sweep(1, cyc);
        chk_final("stuck0", 225, 14400, 225, -14400);

        full_sweep(2, cyc);
        chk_final("plus1", 256, 256, 1, 256);
        chk("plus1_op_a", bus.op_a, 15);
        chk("plus1_op_b", bus.op_b, 15);

        // Second start at cycle 100 must be ignored.
        mode = 3;
        pulse_start();
        cyc = 1;
        while (cyc < 99) begin @(negedge clk); cyc++; end
        bus.start = 1'b1;
        @(negedge clk); cyc++;
        bus.start = 1'b0;
        chk("restart_busy", bus.busy, 1);
        wait_done(cyc, cyc);
        metrics_after(3, 256, c, s, mx, bi);
        chk_final("xor", c, s, mx, bi);

        // Back-to-back start out of DONE.
        pulse_start();
        chk("b2b_done", bus.done, 0);
        chk("b2b_busy", bus.busy, 1);
        chk_final("b2b_clr", 0, 0, 0, 0);
        wait_done(1, cyc);
        chk_final("b2b", c, s, mx, bi);

        // Reset mid-sweep, then a clean exact sweep.
        mode = 1;
        pulse_start();
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_op_a", bus.op_a, 0);
        chk_final("mid_rst", 0, 0, 0, 0);
        full_sweep(0, cyc);
        chk_final("post_rst", 0, 0, 0, 0);

        @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
